// File: rtl/oam_dma_if.sv
// oam_dma_if -- CPU-side and memory-side bus bundle for the sprite-DMA block.
//   cpu_addr/cpu_wdata/cpu_rw : CPU memory port request
//   cpu_rdy                   : CPU ready (0 stalls the CPU)
//   mem_addr/mem_wdata/mem_rw : arbitrated external memory request
//   mem_rdata                 : external memory read data (combinational)
//   dma_busy                  : transfer in progress
// modport slave  : the arbiter (oam_dma_ctrl)
// modport master : the surrounding CPU + memory environment
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rw;
  logic [7:0]  mem_rdata;
  logic        dma_busy;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rw, mem_rdata,
    output cpu_rdy, mem_addr, mem_wdata, mem_rw, dma_busy
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rw, mem_rdata,
    input  cpu_rdy, mem_addr, mem_wdata, mem_rw, dma_busy
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl -- sprite-DMA sequencer and memory-bus arbiter.
// A CPU write to TRIG_ADDR stalls the CPU and copies page {data,00..FF}
// to OAM_ADDR, one read/write pair per two cycles, then releases the bus.
// Ports:
//   clk  : system clock (rising edge)
//   rst  : synchronous, active-high reset
//   bus  : oam_dma_if.slave (CPU request, memory request, cpu_rdy, dma_busy)
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | bus pass-through, CPU running, watching for the trigger
// ST_HALT  | CPU stalled, bus reads only; picks ALIGN or READ by parity
// ST_ALIGN | one wait cycle so every READ lands on a get (par=0) cycle
// ST_READ  | read {page,cnt}, latch the byte
// ST_WRITE | write latched byte to OAM_ADDR; advance or finish
module oam_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input logic       clk,
  input logic       rst,
  oam_dma_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  logic [2:0] state;
  logic [7:0] page;
  logic [7:0] cnt;
  logic [7:0] data_buf;
  logic       par;
  logic       trig;

  assign trig = (state == ST_IDLE) && !bus.cpu_rw && (bus.cpu_addr == TRIG_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      page     <= 8'h00;
      cnt      <= 8'h00;
      data_buf <= 8'h00;
      par      <= 1'b0;
    end else begin
      par <= ~par;
      case (state)
        ST_IDLE: begin
          if (trig) begin
            page  <= bus.cpu_wdata;
            cnt   <= 8'h00;
            state <= ST_HALT;
          end
        end
        // par=1 now means the next cycle is a get cycle
        ST_HALT:  state <= par ? ST_READ : ST_ALIGN;
        ST_ALIGN: state <= ST_READ;
        ST_READ: begin
          data_buf <= bus.mem_rdata;
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          if (cnt == 8'hFF) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= cnt + 8'd1;
            state <= ST_READ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_rw    = bus.cpu_rw;
    bus.cpu_rdy   = 1'b1;
    bus.dma_busy  = (state != ST_IDLE);
    case (state)
      ST_HALT, ST_ALIGN: begin
        // stalled CPU may still present a write; force a harmless read
        bus.mem_rw  = 1'b1;
        bus.cpu_rdy = 1'b0;
      end
      ST_READ: begin
        // low byte is cnt only: no carry into page at $xxFF
        bus.mem_addr = {page, cnt};
        bus.mem_rw   = 1'b1;
        bus.cpu_rdy  = 1'b0;
      end
      ST_WRITE: begin
        bus.mem_addr  = OAM_ADDR;
        bus.mem_wdata = data_buf;
        bus.mem_rw    = 1'b0;
        bus.cpu_rdy   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oam_dma_if bus();

  oam_dma_ctrl #(.TRIG_ADDR(16'h4014), .OAM_ADDR(16'h2004)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [7:0] mem_model [0:65535];
  assign bus.mem_rdata = mem_model[bus.mem_addr];

  // independent parity model: 0 in the first cycle after reset
  logic tpar = 1'b0;
  always @(posedge clk) tpar <= rst ? 1'b0 : ~tpar;

  int n_pass  = 0;
  int n_total = 0;

  // scoreboard entry: {busy, rw, addr, wdata (0 on reads)}
  logic [25:0] exp_q [$];

  logic [15:0] d_addr;
  logic [7:0]  d_wdata;
  logic        d_rw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
    d_addr  = a;
    d_wdata = d;
    d_rw    = rw;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_rw    = rw;
  endtask

  // idle pass-through: everything the CPU drives reaches memory unchanged
  task automatic check_pass(input string tag);
    chk(tag, {6'd0, bus.cpu_rdy, bus.dma_busy, bus.mem_addr, bus.mem_wdata, bus.mem_rw},
             {6'd0, 1'b1, 1'b0, d_addr, d_wdata, d_rw});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // trigger a transfer when the model parity equals trig_par;
  // abort_at>0 asserts rst during the abort_at-th DMA bus cycle
  task automatic run_dma(input logic [7:0] page, input logic trig_par, input int abort_at);
    logic par_halt;
    int   exp_stall;
    int   stall;
    int   popped;
    bit   done;
    bit   aborted;
    logic [25:0] e;
    for (int k = 0; k < 4 && tpar !== trig_par; k++) begin
      drive(16'h0123, 8'h00, 1'b1);
      step();
    end
    drive(16'h4014, page, 1'b0);
    par_halt  = ~tpar;
    exp_stall = par_halt ? 513 : 514;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({1'b1, 1'b1, page, i[7:0], 8'h00});
      exp_q.push_back({1'b1, 1'b0, 16'h2004, mem_model[{page, i[7:0]}]});
    end
    @(negedge clk);
    check_pass($sformatf("trig_pass_%02h", page));
    step();
    drive(16'h1234, 8'hEE, 1'b0);
    stall   = 0;
    popped  = 0;
    done    = 0;
    aborted = 0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clk);
      if (bus.cpu_rdy === 1'b1) begin
        done = 1;
        check_pass($sformatf("release_%02h", page));
      end else begin
        if (stall == 0 || (stall == 1 && !par_halt)) begin
          chk($sformatf("halt_bus_%02h_%0d", page, stall),
              {bus.dma_busy, bus.mem_rw, bus.mem_addr}, {1'b1, 1'b1, 16'h1234});
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          popped++;
          chk($sformatf("dma_%02h_%0d", page, popped),
              {bus.dma_busy, bus.mem_rw, bus.mem_addr, bus.mem_rw ? 8'h00 : bus.mem_wdata}, e);
          if (popped == abort_at) rst = 1'b1;
        end
        stall++;
      end
      step();
      if (rst) begin
        rst = 1'b0;
        drive(16'h1111, 8'h22, 1'b0);
        @(negedge clk);
        check_pass("abort_pass");
        step();
        exp_q.delete();
        aborted = 1;
        done    = 1;
      end
    end
    if (!aborted) begin
      chk($sformatf("stall_len_%02h", page), stall, exp_stall);
      chk($sformatf("q_empty_%02h", page), exp_q.size(), 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem_model[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem_model[16'h0300 + i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 256; i++) mem_model[16'h0200 + i] = 8'(i * 3 + 1);

    rst = 1'b1;
    drive(16'h0000, 8'h00, 1'b1);
    step();
    step();
    rst = 1'b0;
    drive(16'hABCD, 8'h11, 1'b1);
    @(negedge clk);
    check_pass("reset_state");
    step();

    // trigger at par=0 -> HALT at par=1, no ALIGN, 513 stall cycles
    run_dma(8'h02, 1'b0, 0);
    // trigger at par=1 -> ALIGN inserted, 514 stall cycles
    run_dma(8'h02, 1'b1, 0);
    // data integrity: writes i^5A
    run_dma(8'h03, 1'b0, 0);
    // page $FF must end at $FFFF, never wrap to $0000
    run_dma(8'hFF, 1'b1, 0);

    drive(16'h4014, 8'h07, 1'b1);
    @(negedge clk); check_pass("nt_read_4014"); step();
    drive(16'h4015, 8'h07, 1'b0);
    @(negedge clk); check_pass("nt_write_4015"); step();
    drive(16'h4013, 8'h07, 1'b0);
    @(negedge clk); check_pass("nt_write_4013"); step();
    drive(16'h0010, 8'h00, 1'b1);
    @(negedge clk); check_pass("nt_after"); step();

    // reset during the READ of byte 100 (scoreboard entry 201), then restart
    run_dma(8'h05, 1'b0, 201);
    run_dma(8'h04, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite-DMA sequencer and memory-bus arbiter for the 2A03 core. It sits between the CPU datapath's memory port (mem_addr_h/l, mem_data, mem_rw) and external memory. A CPU write to $4014 halts the CPU via a ready line, and the block then copies 256 bytes from page $XX00–$XXFF to the OAM data port at $2004, one read/write pair per two cycles. It then releases the bus.

## Interface
Parameters:
- TRIG_ADDR, 16'h4014: CPU write address that starts a transfer.
- OAM_ADDR, 16'h2004: destination address for every DMA write.

Ports:
- clk  in  1  system clock; one clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address, {mem_addr_h, mem_addr_l}.
- cpu_wdata  in  8  CPU write data.
- cpu_rw  in  1  CPU direction; 1 = read, 0 = write.
- cpu_rdy  out  1  CPU ready; 0 stalls the CPU controller in its current cycle.
- mem_addr  out  16  arbitrated memory address.
- mem_wdata  out  8  arbitrated write data.
- mem_rw  out  1  arbitrated direction; 1 = read.
- mem_rdata  in  8  memory read data, valid combinationally in the same cycle.
- dma_busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Registers:
  - page[7:0]: source high byte.
  - cnt[7:0]: byte offset.
  - buf[7:0]: latched byte.
  - par: cycle parity. Toggles every cycle, reset 0. par=0 is a "get" cycle, par=1 a "put" cycle.
- IDLE:
  - Bus is pass-through: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_rw=cpu_rw.
  - cpu_rdy=1.
  - Trigger is cpu_rw=0 && cpu_addr==TRIG_ADDR. On trigger: page<=cpu_wdata, cnt<=0, next state HALT. The trigger write itself still reaches memory (pass-through).
  - Any other access, including a read of TRIG_ADDR or a write to TRIG_ADDR+1, does not trigger.
- HALT:
  - cpu_rdy=0. Bus passes cpu_addr with mem_rw forced to 1, so no CPU write can leak.
  - Next state is READ if par==1 (the next cycle is a get cycle), else ALIGN.
- ALIGN: same outputs as HALT; next state READ.
- READ:
  - mem_addr={page,cnt}, mem_rw=1, cpu_rdy=0.
  - buf<=mem_rdata at the end of the cycle; next state WRITE.
- WRITE:
  - mem_addr=OAM_ADDR, mem_wdata=buf, mem_rw=0, cpu_rdy=0.
  - If cnt==8'hFF: next state IDLE. Otherwise cnt<=cnt+1 and next state READ.
- Address arithmetic: the low byte is cnt only. No carry into page; page $FF reads $FF00–$FFFF and never touches $0000.
- A trigger cannot occur while busy, because the CPU is stalled and the bus is owned by the DMA.
- rst, including mid-transfer:
  - state<=IDLE, cnt<=0, buf<=0, page<=0, par<=0.
  - The next cycle is pass-through with cpu_rdy=1. The partial transfer is abandoned, not resumed.

## Timing
- Reset values: cpu_rdy=1, dma_busy=0. mem_* equal the CPU inputs.
- All outputs are combinational from state plus registers and the CPU inputs. There is no output register stage.
- Trigger in cycle T (IDLE). cpu_rdy falls in cycle T+1 (HALT).
- Stall length, counted from HALT through the final WRITE:
  - 513 cycles if par=1 in HALT.
  - 514 cycles if par=0 in HALT (one ALIGN cycle).
- cpu_rdy returns to 1 in the cycle immediately after the final WRITE.
- All READs occur on par=0 cycles and all WRITEs on par=1 cycles.
- Byte i: read at {page,i} in a READ cycle, written to OAM_ADDR in the immediately following cycle.

## Test plan
- Parity-odd start: reset, idle 1 cycle, then write $4014=$02 so HALT has par=1. Required: no ALIGN; cpu_rdy low for exactly 513 cycles; 256 reads $0200..$02FF in order, each followed by a write to $2004.
- Parity-even start: same as above, one cycle later. Required: one ALIGN cycle; cpu_rdy low for exactly 514 cycles; first READ on a par=0 cycle.
- Data integrity: preload $0300+i = i^8'h5A, trigger with $03. Required: the $2004 write sequence is $5A,$5B,…,$A5 (i^$5A for i=0..255), with no missing or duplicated writes.
- Page $FF boundary: trigger with $FF. Required: last read at $FFFF, then IDLE; no access to $0000.
- Reset mid-transfer: assert rst during the READ of byte 100. Required: next cycle is IDLE with cpu_rdy=1, dma_busy=0, and pass-through active. A new $4014=$04 trigger restarts at $0400.
- Non-triggers: read $4014, write $4015, write $4013. Required: dma_busy stays 0, cpu_rdy stays 1, and all accesses pass through unchanged.
